// File: rtl/rf_wb_pkg.sv
// Shared types and default sizes for the register-file writeback scheduler.
package rf_wb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int unsigned RF_ADDR_W   = 5;
   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_NUM_REGS = 32;

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter; last_grant only moves on a real grant.
module rr_arb2
   import rf_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic r_last;

   // One-hot grant; on a tie the port not granted last wins.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Remember which port was granted; reset favours port 0 on the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (enable && (|req)) begin
         r_last <= grant[1];
      end
   end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-port scheduler for the register file: arbitrates ALU/load writebacks
// onto we3/wa3/wd3 and suppresses writes to r0.
// Optional build macro RF_CLEAR_EN adds a post-reset sweep zeroing r1..r(N-1).
module rf_wb_sched
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned DATA_W   = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              busy
);

   // Reject register counts the address bus cannot cover.
   if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_cfg_chk
      $error("rf_wb_sched: NUM_REGS does not fit ADDR_W");
   end

`ifdef RF_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
`else
   localparam state_t RST_STATE = RUN;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_we;
   logic [ADDR_W-1:0] r_wa;
   logic [DATA_W-1:0] r_wd;
   logic              w_we_nxt;
   logic [ADDR_W-1:0] w_wa_nxt;
   logic [DATA_W-1:0] w_wd_nxt;
   logic              w_run;
   logic [1:0]        w_grant;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;

   assign w_run = (r_state == RUN) && !rst;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({req1_valid, req0_valid}),
      .enable (w_run),
      .grant  (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign w_sel_addr = w_grant[1] ? req1_addr : req0_addr;
   assign w_sel_data = w_grant[1] ? req1_data : req0_data;

   // Next state and next write-port values.
   always_comb begin
      w_state_nxt = r_state;
      w_we_nxt    = 1'b0;
      w_wa_nxt    = r_wa;
      w_wd_nxt    = r_wd;
`ifdef RF_CLEAR_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
`ifdef RF_CLEAR_EN
         CLEAR: begin
            w_we_nxt  = 1'b1;
            w_wa_nxt  = r_cnt;
            w_wd_nxt  = '0;
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            if (r_cnt == LAST_ADDR) begin
               w_state_nxt = RUN;
            end
         end
`endif
         RUN: begin
            // Accepted writes to r0 are swallowed so r0 stays zero.
            if ((|w_grant) && (w_sel_addr != '0)) begin
               w_we_nxt = 1'b1;
               w_wa_nxt = w_sel_addr;
               w_wd_nxt = w_sel_data;
            end
         end
         default: w_state_nxt = RST_STATE;
      endcase
   end

   // State, sweep counter and registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RST_STATE;
         r_we    <= 1'b0;
         r_wa    <= '0;
         r_wd    <= '0;
`ifdef RF_CLEAR_EN
         r_cnt   <= ADDR_W'(1);
`endif
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_we_nxt;
         r_wa    <= w_wa_nxt;
         r_wd    <= w_wd_nxt;
`ifdef RF_CLEAR_EN
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   assign rf_we = r_we;
   assign rf_wa = r_wa;
   assign rf_wd = r_wd;

`ifdef RF_CLEAR_EN
   assign busy = (r_state == CLEAR);
`else
   assign busy = 1'b0;
`endif

endmodule
